// File: rtl/mux16_arbiter.sv
// Round-robin arbiter that owns the select of a shared 16:1 mux.
// Grants are held for up to MAX_BURST beats, and an IDLE cycle always separates two owners.
module mux16_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] req,
    input  logic        ready,
    output logic [15:0] grant,
    output logic [3:0]  s,
    output logic        valid
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);

    state_t      state, state_n;
    logic [3:0]  ptr, ptr_n;
    logic [3:0]  s_n;
    logic [7:0]  cnt, cnt_n;
    logic [15:0] grant_n;
    logic        xfer;
    logic        release_now;

    // First set bit of r, scanning upward from start with modulo-16 wrap.
    function automatic logic [3:0] rr_pick(input logic [15:0] r, input logic [3:0] start);
        logic [3:0] idx;
        logic       found;
        rr_pick = start;
        found   = 1'b0;
        for (int k = 0; k < 16; k++) begin
            idx = start + 4'(k);
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    assign valid       = (state == BUSY) && req[s];
    assign xfer        = valid && ready;
    assign release_now = !req[s] || (xfer && (cnt == LAST_BEAT));

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        s_n     = s;
        cnt_n   = cnt;
        grant_n = grant;
        case (state)
            IDLE: begin
                grant_n = '0;
                cnt_n   = '0;
                if (|req) begin
                    s_n     = rr_pick(req, ptr);
                    grant_n = 16'b1 << s_n;
                    state_n = BUSY;
                end
            end
            BUSY: begin
                if (release_now) begin
                    state_n = IDLE;
                    grant_n = '0;
                    cnt_n   = '0;
                    ptr_n   = s + 4'd1;
                end else if (xfer) begin
                    cnt_n = cnt + 8'd1;
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            s     <= '0;
            cnt   <= '0;
            grant <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            s     <= s_n;
            cnt   <= cnt_n;
            grant <= grant_n;
        end
    end

endmodule

// File: doc/mux16_arbiter.md
MUX16_ARBITER -- requirements
Module: mux16_arbiter

Interface
REQ-001 SHALL have parameter MAX_BURST, default 4, meaning the maximum beats transferred per grant before forced rotation (legal 1..255).
REQ-002 SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port req, input, 16 bits: req[i] high means requester i has a beat pending for the shared 16:1 mux.
REQ-005 SHALL have port ready, input, 1 bit: the downstream consumer of the mux output accepts the current beat.
REQ-006 SHALL have port grant, output, 16 bits: one-hot owner of the mux, or all zero.
REQ-007 SHALL have port s, output, 4 bits: binary index of the owner, wired directly to the select of the shared 16:1 mux.
REQ-008 SHALL have port valid, output, 1 bit: the mux output carries a valid beat this cycle.

Function
REQ-009 SHALL implement two states, IDLE and BUSY, plus registers ptr[3:0] (round-robin priority start) and cnt[7:0] (beats in the current grant).
REQ-010 In IDLE with req != 0, SHALL select the first i with req[i]=1, searching ptr, ptr+1, ... mod 16, and SHALL register grant=1<<i, s=i, cnt=0 and state=BUSY at the next edge.
REQ-011 In IDLE with req == 0, SHALL hold grant=0, keep s at its last value, and remain in IDLE.
REQ-012 SHALL drive valid combinationally as (state==BUSY) && req[s]; valid SHALL be 0 in IDLE.
REQ-013 A beat transfers on an edge where valid && ready; cnt SHALL increment by 1 on each transfer and otherwise hold.
REQ-014 In BUSY, SHALL release the grant at the next edge when req[s]==0, or when a transfer occurs with cnt==MAX_BURST-1.
REQ-015 On release, SHALL set state=IDLE, grant=0, cnt=0 and ptr=(s+1) mod 16; the 4-bit add SHALL wrap from 15 to 0.
REQ-016 Release SHALL always insert exactly one IDLE cycle, so no two consecutive cycles carry grants to different owners.
REQ-017 In BUSY with no release condition (req[s]=1 and either ready=0 or cnt<MAX_BURST-1), SHALL hold grant, s and state unchanged.
REQ-018 Requests from non-owners during BUSY SHALL be ignored until the next IDLE cycle.
REQ-019 grant SHALL always equal 1<<s when in BUSY and 0 when in IDLE; grant SHALL never have more than one bit set.
REQ-020 Grant latency from a request in IDLE SHALL be exactly 1 cycle.
REQ-021 Every requester with continuously asserted req SHALL be granted within 15 release events.

Reset
REQ-022 While rst=1, SHALL immediately and asynchronously force state=IDLE, grant=0, s=0, ptr=0, cnt=0 and valid=0, including mid-burst.
REQ-023 After rst deasserts, the first arbitration SHALL start the search at index 0.

Verification
REQ-024 Reset then req=16'h0001, ready=1 held -> grant=16'h0001 one cycle later; 4 transfers; IDLE one cycle; grant=16'h0001 again (sole requester); ptr=1.
REQ-025 req=16'hFFFF, ready=1 held from reset -> grants issued in order s=0,1,...,15,0, each holding 4 cycles with a single IDLE gap between grants.
REQ-026 Owner s=5 with ready=0 for 10 cycles -> grant=16'h0020 held, cnt stays 0, valid=1 throughout; other requests ignored.
REQ-027 Owner s=15 drops req after 2 beats -> IDLE next cycle, ptr=0; with req=16'h8001 pending, the next grant is s=0.
REQ-028 rst asserted mid-burst (s=9, cnt=2) -> grant=0, valid=0 and s=0 within the same cycle; after release, req=16'h0200 is granted with cnt=0.
REQ-029 MAX_BURST=1, req=16'h0006, ready=1 -> alternating grants s=1, s=2, one beat each, separated by IDLE cycles.
